// File: rtl/pc_flow_monitor.sv
// Fetch-PC sequencing monitor: each cycle the PC must hold on stall or advance by STEP,
// unless a branch/JAL/JALR is still unresolved in a tracked stage; first violation captured.
module pc_flow_monitor #(
  parameter int              XLEN         = 32,
  parameter int              STEP         = 4,
  parameter logic [XLEN-1:0] PC_RESET     = '0,
  parameter int              BR_RESOLVE   = 2,
  parameter int              JAL_RESOLVE  = 2,
  parameter int              JALR_RESOLVE = 3,
  parameter int              ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      pc_reg,
  input  logic [6:0]           opcode_id,
  input  logic                 if_id_write_s,
  input  logic                 flush_s,
  input  logic                 check_en,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [XLEN-1:0]      err_pc,
  output logic [XLEN-1:0]      err_pc_prev
);

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam int DEPTH_BJ = (BR_RESOLVE > JAL_RESOLVE) ? BR_RESOLVE : JAL_RESOLVE;
  localparam int DEPTH    = (DEPTH_BJ > JALR_RESOLVE) ? DEPTH_BJ : JALR_RESOLVE;
  // Stage 1 is opcode_id itself; registered stages run 2..SDEPTH (at least one kept).
  localparam int SDEPTH   = (DEPTH < 2) ? 2 : DEPTH;

  logic [6:0]           stage_q [2:SDEPTH];
  logic [XLEN-1:0]      pc_prev_q;
  logic                 prev_valid_q;
  logic                 err_q, err_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [XLEN-1:0]      err_pc_q, err_pc_d;
  logic [XLEN-1:0]      err_pc_prev_q, err_pc_prev_d;
  logic                 blocked;
  logic                 pc_ok;
  logic                 viol;

  function automatic logic blocks_at(input logic [6:0] op, input int k);
    return ((op == OP_BR)   && (k <= BR_RESOLVE))  ||
           ((op == OP_JAL)  && (k <= JAL_RESOLVE)) ||
           ((op == OP_JALR) && (k <= JALR_RESOLVE));
  endfunction

  always_comb begin
    blocked = blocks_at(opcode_id, 1);
    for (int k = 2; k <= SDEPTH; k++) begin
      blocked = blocked | blocks_at(stage_q[k], k);
    end
  end

  always_comb begin
    pc_ok = 1'b0;
    if (pc_reg == PC_RESET) begin
      pc_ok = 1'b1;
    end else if (if_id_write_s) begin
      pc_ok = (pc_reg == pc_prev_q);
    end else begin
      pc_ok = (pc_reg == (pc_prev_q + XLEN'(STEP)));
    end
    viol = check_en & prev_valid_q & ~blocked & ~pc_ok;
  end

  always_comb begin
    err_d         = viol;
    err_sticky_d  = err_sticky_q;
    err_cnt_d     = err_cnt_q;
    err_pc_d      = err_pc_q;
    err_pc_prev_d = err_pc_prev_q;
    if (viol && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
    // Only the first violation since reset is captured.
    if (viol && !err_sticky_q) begin
      err_sticky_d  = 1'b1;
      err_pc_d      = pc_reg;
      err_pc_prev_d = pc_prev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 2; k <= SDEPTH; k++) begin
        stage_q[k] <= '0;
      end
      pc_prev_q     <= '0;
      prev_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_cnt_q     <= '0;
      err_pc_q      <= '0;
      err_pc_prev_q <= '0;
    end else begin
      // Shifts regardless of stall; a squashed instruction enters EX as a bubble.
      stage_q[2] <= flush_s ? 7'd0 : opcode_id;
      for (int k = 3; k <= SDEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
      pc_prev_q     <= pc_reg;
      prev_valid_q  <= 1'b1;
      err_q         <= err_d;
      err_sticky_q  <= err_sticky_d;
      err_cnt_q     <= err_cnt_d;
      err_pc_q      <= err_pc_d;
      err_pc_prev_q <= err_pc_prev_d;
    end
  end

  assign err         = err_q;
  assign err_sticky  = err_sticky_q;
  assign err_cnt     = err_cnt_q;
  assign err_pc      = err_pc_q;
  assign err_pc_prev = err_pc_prev_q;

endmodule

// File: tb/tb_pc_flow_monitor.sv
// Bench for pc_flow_monitor: two instances (default, and JALR_RESOLVE=2 / ERR_CNT_W=2)
// share stimulus; a cycle model predicts every output vector into per-instance queues.
module tb_pc_flow_monitor;

  localparam logic [6:0] OP_NOP  = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // ---------------- clock / reset / DUTs ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_reg;
  logic [6:0]  opcode_id;
  logic        if_id_write_s, flush_s, check_en;

  logic        err_a, sticky_a;
  logic [7:0]  cnt_a;
  logic [31:0] epc_a, eprev_a;
  logic        err_b, sticky_b;
  logic [1:0]  cnt_b;
  logic [31:0] epc_b, eprev_b;

  always #5 clk = ~clk;

  pc_flow_monitor dut (
    .clk(clk), .reset(reset), .pc_reg(pc_reg), .opcode_id(opcode_id),
    .if_id_write_s(if_id_write_s), .flush_s(flush_s), .check_en(check_en),
    .err(err_a), .err_sticky(sticky_a), .err_cnt(cnt_a),
    .err_pc(epc_a), .err_pc_prev(eprev_a)
  );

  pc_flow_monitor #(.JALR_RESOLVE(2), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .pc_reg(pc_reg), .opcode_id(opcode_id),
    .if_id_write_s(if_id_write_s), .flush_s(flush_s), .check_en(check_en),
    .err(err_b), .err_sticky(sticky_b), .err_cnt(cnt_b),
    .err_pc(epc_b), .err_pc_prev(eprev_b)
  );

  // ---------------- scoreboard state ----------------
  logic [73:0] exp_q_a[$];
  logic [73:0] exp_q_b[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int          cyc = 0;
  int          blk_end [2];
  int          cnt_m   [2];
  bit          sticky_m[2];
  logic [31:0] epc_m   [2];
  logic [31:0] eprev_m [2];
  bit          err_m   [2];
  int          cnt_max [2] = '{255, 3};
  int          jalr_r  [2] = '{3, 2};
  logic [31:0] prev_m;
  bit          pvalid_m;

  function automatic logic [73:0] pack(input logic e, input logic s, input logic [7:0] c,
                                       input logic [31:0] p, input logic [31:0] pp);
    return {e, s, c, p, pp};
  endfunction

  function automatic int res_of(input int i, input logic [6:0] op);
    if (op == OP_BR)   return 2;
    if (op == OP_JAL)  return 2;
    if (op == OP_JALR) return jalr_r[i];
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs(input string tag);
    logic [73:0] ea, eb;
    ea = exp_q_a.pop_front();
    eb = exp_q_b.pop_front();
    chk({tag, "/a"}, pack(err_a, sticky_a, cnt_a, epc_a, eprev_a), ea);
    chk({tag, "/b"}, pack(err_b, sticky_b, {6'd0, cnt_b}, epc_b, eprev_b), eb);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      blk_end[i] = -1; cnt_m[i] = 0; sticky_m[i] = 0;
      epc_m[i] = '0; eprev_m[i] = '0; err_m[i] = 0;
    end
    prev_m = '0; pvalid_m = 0;
    exp_q_a.push_back('0);
    exp_q_b.push_back('0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    reset = 1'b1;
    pc_reg = $urandom; opcode_id = OP_JALR; flush_s = 1'b0;
    if_id_write_s = 1'b0; check_en = 1'b1;
    for (int c = 0; c < n; c++) begin
      model_reset();
      cyc++;
      @(posedge clk); #1;
      compare_outputs("reset");
    end
    reset = 1'b0;
  endtask

  task automatic step(input logic [31:0] pc, input logic [6:0] op = OP_NOP,
                      input logic stall = 1'b0, input logic flush = 1'b0,
                      input logic en = 1'b1);
    pc_reg = pc; opcode_id = op; if_id_write_s = stall; flush_s = flush; check_en = en;
    for (int i = 0; i < 2; i++) begin
      int r;
      bit blk, good, viol;
      r    = res_of(i, op);
      blk  = (cyc <= blk_end[i]) || (r > 0);
      good = (pc == 32'd0) || (stall ? (pc == prev_m) : (pc == prev_m + 32'd4));
      viol = en && pvalid_m && !blk && !good;
      if ((r > 0) && !flush && (cyc + r - 1 > blk_end[i])) blk_end[i] = cyc + r - 1;
      err_m[i] = viol;
      if (viol && (cnt_m[i] < cnt_max[i])) cnt_m[i]++;
      if (viol && !sticky_m[i]) begin
        sticky_m[i] = 1; epc_m[i] = pc; eprev_m[i] = prev_m;
      end
    end
    exp_q_a.push_back(pack(err_m[0], sticky_m[0], 8'(cnt_m[0]), epc_m[0], eprev_m[0]));
    exp_q_b.push_back(pack(err_m[1], sticky_m[1], 8'(cnt_m[1]), epc_m[1], eprev_m[1]));
    prev_m = pc; pvalid_m = 1; cyc++;
    @(posedge clk); #1;
    compare_outputs("cycle");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] pc;
    int sel;
    do_reset(2);

    // Sequential fetch
    step(0); step(4); step(8); step(12);
    chk("seq_cnt", {66'd0, cnt_a}, 74'd0);

    // Stall then skip 4 -> 12
    step(0); step(4); step(4, OP_NOP, 1'b1);
    chk("stall_ok", {73'd0, err_a}, 74'd0);
    step(12);
    chk("skip_err",    {73'd0, err_a},    74'd1);
    chk("skip_pc",     {42'd0, epc_a},    74'd12);
    chk("skip_prev",   {42'd0, eprev_a},  74'd4);
    chk("skip_cnt",    {66'd0, cnt_a},    74'd1);
    chk("skip_sticky", {73'd0, sticky_a}, 74'd1);

    // JALR window, legal landing
    do_reset(1);
    step(0); step(4); step(8, OP_JALR); step(100); step(104); step(108);
    chk("jalr_sticky_a", {73'd0, sticky_a}, 74'd0);
    chk("jalr_sticky_b", {73'd0, sticky_b}, 74'd0);

    // JALR window, second jump at t+2: only the RESOLVE=2 instance flags
    do_reset(1);
    step(0); step(4); step(8, OP_JALR); step(100); step(200);
    chk("jalr3_err", {73'd0, err_a}, 74'd0);
    chk("jalr2_err", {73'd0, err_b}, 74'd1);
    chk("jalr2_pc",  {42'd0, epc_b}, 74'd200);

    // Flushed branch only blocks its own cycle
    do_reset(1);
    step(0); step(4, OP_BR, 1'b0, 1'b1); step(100);
    chk("flush_err", {73'd0, err_a}, 74'd1);

    // Stall together with a blocker: no check
    do_reset(1);
    step(0); step(4); step(300, OP_BR, 1'b1); step(304);
    chk("stall_blk", {73'd0, sticky_a}, 74'd0);

    // Checking disabled across a jump, re-enabled next cycle
    step(500, OP_NOP, 1'b0, 1'b0, 1'b0); step(504);
    chk("en_off", {73'd0, sticky_a}, 74'd0);

    // Saturation with five violations, then reset
    do_reset(1);
    step(0); step(100); step(200); step(300); step(400); step(500);
    chk("sat_cnt_b",  {72'd0, cnt_b}, 74'd3);
    chk("sat_cnt_a",  {66'd0, cnt_a}, 74'd5);
    chk("sat_pc_b",   {42'd0, epc_b}, 74'd100);
    chk("sat_err_b",  {73'd0, err_b}, 74'd1);
    do_reset(1);
    step(32'h1234); step(32'h1238);
    chk("post_reset", {73'd0, sticky_a}, 74'd0);

    // Wrap-around
    do_reset(1);
    step(32'hFFFF_FFF8); step(32'hFFFF_FFFC); step(0); step(4);
    chk("wrap", {73'd0, sticky_a}, 74'd0);

    // Randomised stretch checked against the model
    do_reset(1);
    pc = 32'd0;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      logic st, fl, en;
      sel = $urandom_range(0, 99);
      case ($urandom_range(0, 5))
        0:       op = OP_BR;
        1:       op = OP_JAL;
        2:       op = OP_JALR;
        default: op = OP_NOP;
      endcase
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 9) != 0);
      if (sel < 70)      pc = st ? pc : pc + 32'd4;
      else if (sel < 90) pc = {$urandom_range(0, 32'h3FFF), 2'b00};
      else if (sel < 95) pc = 32'd0;
      else               pc = pc + 32'd8;
      step(pc, op, st, fl, en);
      if ($urandom_range(0, 149) == 0) do_reset(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_flow_monitor.md
# pc_flow_monitor

Synthesizable, parametrised PC-sequencing monitor for the RV32IMA pipeline. It is bound beside the core in simulation, formal and FPGA-debug builds. Each cycle it checks that the fetch PC either holds during a stall or advances by a fixed step, unless a control-flow instruction is still unresolved in a tracked pipeline stage. Violations are reported as a pulse, a sticky flag, a saturating count and a capture of the first failing PC pair.

## Interface
Parameters:
- XLEN, 32, PC width.
- STEP, 4, required PC increment on a non-stalled, unblocked cycle.
- PC_RESET, 0, PC value always accepted (reset/trap vector).
- BR_RESOLVE, 2, last stage (1=ID, 2=EX, 3=MEM, ...) in which a branch (7'b1100011) blocks checking.
- JAL_RESOLVE, 2, same for JAL (7'b1101111).
- JALR_RESOLVE, 3, same for JALR (7'b1100111).
- ERR_CNT_W, 8, error counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_reg  in  XLEN  current fetch PC.
- opcode_id  in  7  opcode of instruction in ID.
- if_id_write_s  in  1  1 = IF/ID hold (stall), PC must hold.
- flush_s  in  1  1 = instruction leaving ID this cycle is squashed (enters EX as bubble).
- check_en  in  1  1 = checking enabled; 0 = no check, pipeline tracking continues.
- err  out  1  one-cycle violation pulse.
- err_sticky  out  1  set on first violation, cleared only by reset.
- err_cnt  out  ERR_CNT_W  saturating violation count.
- err_pc  out  XLEN  pc_reg at first violation.
- err_pc_prev  out  XLEN  previous-cycle PC at first violation.

## Operation
- DEPTH = max(BR_RESOLVE, JAL_RESOLVE, JALR_RESOLVE). The monitor keeps an opcode shift register stage[1..DEPTH], where stage[1] = opcode_id (combinational).
- Each cycle, stage[2] <= flush_s ? 0 : opcode_id and stage[k+1] <= stage[k] for k>=2. The register shifts regardless of stall.
- blocked = any k where (stage[k]==branch and k<=BR_RESOLVE) or (stage[k]==JAL and k<=JAL_RESOLVE) or (stage[k]==JALR and k<=JALR_RESOLVE).
- pc_prev <= pc_reg every cycle. prev_valid <= 1 every cycle after reset, and is 0 in the first cycle after reset.
- check = check_en & prev_valid & !blocked.
- Expected value when if_id_write_s=1: pc_reg == pc_prev.
- Expected value when if_id_write_s=0: pc_reg == (pc_prev + STEP) mod 2^XLEN.
- pc_reg == PC_RESET is always accepted.
- viol = check & !expected.
- err <= viol. err_cnt <= err_cnt+1 on viol, saturating at all-ones.
- On viol with err_sticky=0: err_sticky <= 1, err_pc <= pc_reg, err_pc_prev <= pc_prev. Later violations update only err and err_cnt.

## Timing
- Reset (reset=1 at an edge): all outputs 0. The stage register, pc_prev and prev_valid are all cleared.
- A reset asserted mid-operation wipes captured error state on the same edge, and the first post-reset cycle is never checked.
- Latency: a violation at cycle t gives err=1 in cycle t+1 only. err_cnt, err_sticky and err_pc* also update at the t+1 edge.
- A control-flow opcode seen in ID at cycle t blocks cycles t..t+R-1, where R is its RESOLVE value. The first checked cycle is t+R, provided no new blocker has appeared.
- PC wrap-around: pc_prev = 2^XLEN - STEP with next PC 0 is legal, via modular add.
- Simultaneous stall and blocker: blocked wins, no check.
- Simultaneous flush and stall: flush still zeroes stage[2].
- With check_en=0, pc_prev and the stages still update, so re-enabling checks at the next cycle is valid immediately.
- The counter saturates: at all-ones it stays put, while err still pulses.

## Test plan
- Sequential fetch: after reset, drive pc_reg 0,4,8,12 with NOP opcodes (7'b0010011). Required: err stays 0, err_cnt=0.
- Stall and skip: drive 0,4,4 with if_id_write_s=1 on the third cycle. Required: no error. Then drive 4→12 unstalled; required: err=1 one cycle later, err_pc=12, err_pc_prev=4, err_cnt=1, err_sticky=1.
- Blocker window: put JALR in ID at pc 8, then drive PC 8→100→104 over the next two cycles. Required: no error (blocked cycles t..t+2, 100→104 legal). With JALR_RESOLVE=2, the same sequence still passes, but a jump to 200 at t+2 flags.
- Flush: branch in ID with flush_s=1, then PC jumps at t+1. Required: err=1, because stage[2] was squashed and only cycle t was blocked.
- Saturation and reset: with ERR_CNT_W=2, inject 5 violations. Required: err_cnt=3, err_sticky=1, err_pc holds the first failure. Then assert reset=1 for one edge; required: all outputs 0, and the next cycle with an arbitrary PC is not flagged.
- Wrap: drive pc_reg 32'hFFFFFFFC → 0 → 4. Required: no error.
